// File: rtl/store_write_buffer_pkg.sv
// Shared types and helpers for the store write buffer.
//   sb_entry_t : one buffered store {addr, data} at the default widths
//   sb_ptr_w() : pointer width for a given depth (log2, minimum 1)
package store_buf_pkg;

  localparam int SB_AW = 32;
  localparam int SB_DW = 32;

  typedef struct packed {
    logic [SB_AW-1:0] addr;
    logic [SB_DW-1:0] data;
  } sb_entry_t;

  function automatic int sb_ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/store_write_buffer_if.sv
// Bus bundle for the store write buffer.
//   Core store side : st_valid, st_addr, st_data -> buffer; st_full <- buffer
//   Load forwarding : ld_addr -> buffer; ld_hit, ld_data <- buffer
//   Memory side     : mem_valid, mem_addr, mem_data <- buffer; mem_ready -> buffer
//   Status          : empty, overflow <- buffer
// Modports: master = core + memory side, slave = the buffer itself.
//
// Handshake: a store is taken on a rising edge where st_valid=1 and st_full=0;
// otherwise the core holds it. A head entry is transferred on a rising edge
// where mem_valid=1 and mem_ready=1; while mem_valid=1 and mem_ready=0 the
// head (mem_addr/mem_data) is held stable. mem_ready is ignored when empty.
interface store_write_buffer_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          st_valid;
  logic [AW-1:0] st_addr;
  logic [DW-1:0] st_data;
  logic          st_full;
  logic [AW-1:0] ld_addr;
  logic          ld_hit;
  logic [DW-1:0] ld_data;
  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          empty;
  logic          overflow;

  modport master (
    output st_valid, st_addr, st_data, ld_addr, mem_ready,
    input  st_full, ld_hit, ld_data, mem_valid, mem_addr, mem_data, empty, overflow
  );

  modport slave (
    input  st_valid, st_addr, st_data, ld_addr, mem_ready,
    output st_full, ld_hit, ld_data, mem_valid, mem_addr, mem_data, empty, overflow
  );
endinterface

// File: rtl/sb_fwd_match.sv
// Youngest-match search for store-to-load forwarding (built only with
// STORE_FWD_EN). Walks the live entries from head (oldest) to head+count-1
// (youngest); later matches overwrite earlier ones so the youngest wins.
// Compare is word-granular: address bits [1:0] are ignored.
//   addr_i/data_i : entry storage
//   head_i/count_i: occupancy
//   ld_addr_i     : lookup address
//   hit_o/data_o  : match flag and youngest matching data
`ifdef STORE_FWD_EN
module sb_fwd_match
  import store_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32,
  parameter int PW    = sb_ptr_w(DEPTH)
) (
  input  logic [AW-1:0] addr_i [DEPTH],
  input  logic [DW-1:0] data_i [DEPTH],
  input  logic [PW-1:0] head_i,
  input  logic [PW:0]   count_i,
  input  logic [AW-1:0] ld_addr_i,
  output logic          hit_o,
  output logic [DW-1:0] data_o
);
  logic [PW-1:0] idx;
  logic          unused_low_bits;

  always_comb begin
    hit_o  = 1'b0;
    data_o = '0;
    idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_i + PW'(i);
      if (((PW+1)'(i) < count_i) && (addr_i[idx][AW-1:2] == ld_addr_i[AW-1:2])) begin
        hit_o  = 1'b1;
        data_o = data_i[idx];
      end
    end
  end

  always_comb begin
    unused_low_bits = ^ld_addr_i[1:0];
    for (int i = 0; i < DEPTH; i++) begin
      unused_low_bits = unused_low_bits ^ (^addr_i[i][1:0]);
    end
  end
endmodule
`endif

// File: rtl/store_write_buffer.sv
// In-order store write buffer between the core's data-store port and a slower
// data memory. Stores are captured in one cycle and drained head-first over a
// valid/ready handshake; the core only stalls (st_full) when every entry is used.
// Ports:
//   clk, reset_n : clock, synchronous active-low reset
//   bus (slave)  : store, load-forwarding, memory and status signals
// Optional feature: STORE_FWD_EN enables store-to-load forwarding (ld_hit/ld_data);
// without it ld_hit and ld_data are tied to 0.
module store_write_buffer
  import store_buf_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = SB_AW,
  parameter int DW    = SB_DW
) (
  input  logic                  clk,
  input  logic                  reset_n,
  store_write_buffer_if.slave   bus
);
  localparam int          PW       = sb_ptr_w(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, push, pop;

  assign empty = (count_q == '0);
  assign full  = (count_q == FULL_CNT);
  // A store arriving while full is refused even if the head pops this cycle.
  assign push  = bus.st_valid && !full;
  assign pop   = !empty && bus.mem_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    ovf_d   = ovf_q | (bus.st_valid & full);
    if (push) tail_d = tail_q + PW'(1);
    if (pop)  head_d = head_q + PW'(1);
    unique case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Entry contents need no reset; occupancy alone says what is live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= bus.st_addr;
      data_q[tail_q] <= bus.st_data;
    end
  end

  assign bus.empty     = empty;
  assign bus.st_full   = full;
  assign bus.mem_valid = !empty;
  assign bus.mem_addr  = addr_q[head_q];
  assign bus.mem_data  = data_q[head_q];
  assign bus.overflow  = ovf_q;

`ifdef STORE_FWD_EN
  sb_fwd_match #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .DW    (DW),
    .PW    (PW)
  ) u_fwd (
    .addr_i    (addr_q),
    .data_i    (data_q),
    .head_i    (head_q),
    .count_i   (count_q),
    .ld_addr_i (bus.ld_addr),
    .hit_o     (bus.ld_hit),
    .data_o    (bus.ld_data)
  );
`else
  logic unused_ld_addr;
  assign unused_ld_addr = ^bus.ld_addr;
  assign bus.ld_hit     = 1'b0;
  assign bus.ld_data    = '0;
`endif

endmodule

// File: tb/tb_store_write_buffer.sv
module tb_store_write_buffer;
  import store_buf_pkg::*;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int DW    = 32;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  store_write_buffer_if #(.AW(AW), .DW(DW)) bus();

  store_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [AW+DW-1:0] exp_q[$];   // {addr, data}, oldest at index 0
  logic             exp_ovf;

  typedef struct {
    logic          sv;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic          mr;
    logic          e_empty;
    logic          e_full;
    logic          e_mv;
    logic          e_ovf;
    logic [AW-1:0] e_addr;
    logic [DW-1:0] e_data;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset(input int n);
    bus.st_valid  = 1'b0;
    bus.mem_ready = 1'b0;
    reset_n       = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    reset_n = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
  endtask

  // Forwarding reference: youngest queued store whose word address matches.
  task automatic check_fwd(input string tag);
`ifdef STORE_FWD_EN
    logic          hit;
    logic [DW-1:0] dat;
    sb_entry_t     e;
    hit = 1'b0;
    dat = '0;
    for (int i = exp_q.size() - 1; i >= 0; i--) begin
      e = exp_q[i];
      if (!hit && (e.addr[AW-1:2] == bus.ld_addr[AW-1:2])) begin
        hit = 1'b1;
        dat = e.data;
      end
    end
    chk({tag, "_hit"}, 64'(bus.ld_hit), 64'(hit));
    if (hit) chk({tag, "_data"}, 64'(bus.ld_data), 64'(dat));
`else
    chk({tag, "_hit_off"}, 64'(bus.ld_hit), 64'd0);
    chk({tag, "_data_off"}, 64'(bus.ld_data), 64'd0);
`endif
  endtask

  // Applies one cycle of inputs and advances the reference model across the edge.
  task automatic cycle(input logic sv, input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic mr, input bit fwd_chk);
    bit do_push, do_pop;
    sb_entry_t e;
    bus.st_valid  = sv;
    bus.st_addr   = a;
    bus.st_data   = d;
    bus.mem_ready = mr;
    if (fwd_chk) begin
      #1;
      check_fwd("fwd");
    end
    do_pop  = mr && (exp_q.size() != 0);
    do_push = sv && (exp_q.size() != DEPTH);
    if (sv && (exp_q.size() == DEPTH)) exp_ovf = 1'b1;
    @(posedge clk);
    if (do_pop) void'(exp_q.pop_front());
    if (do_push) begin
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    sb_entry_t e;
    chk({tag, "_empty"}, 64'(bus.empty), 64'(exp_q.size() == 0));
    chk({tag, "_full"}, 64'(bus.st_full), 64'(exp_q.size() == DEPTH));
    chk({tag, "_mem_valid"}, 64'(bus.mem_valid), 64'(exp_q.size() != 0));
    chk({tag, "_overflow"}, 64'(bus.overflow), 64'(exp_ovf));
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      chk({tag, "_mem_addr"}, 64'(bus.mem_addr), 64'(e.addr));
      chk({tag, "_mem_data"}, 64'(bus.mem_data), 64'(e.data));
    end
  endtask

  // ---------------- test ----------------
  initial begin
    // Fill with backpressure, overflow, then in-order drain.
    //            sv    addr    data   mr    empty full  mv    ovf   head addr / data
    tbl[0] = '{1'b1, 32'h0,  32'h1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1};
    tbl[1] = '{1'b1, 32'h4,  32'h2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1};
    tbl[2] = '{1'b1, 32'h8,  32'h3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'h0, 32'h1};
    tbl[3] = '{1'b1, 32'hC,  32'h4, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 32'h1};
    tbl[4] = '{1'b1, 32'h10, 32'h5, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h1};
    tbl[5] = '{1'b0, 32'h0,  32'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0, 32'h1};
    tbl[6] = '{1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h4, 32'h2};
    tbl[7] = '{1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h8, 32'h3};
    tbl[8] = '{1'b0, 32'h0,  32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'hC, 32'h4};
    tbl[9] = '{1'b0, 32'h0,  32'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0};

    bus.st_valid  = 1'b0;
    bus.st_addr   = '0;
    bus.st_data   = '0;
    bus.ld_addr   = '0;
    bus.mem_ready = 1'b0;
    exp_ovf       = 1'b0;

    // Reset / idle
    do_reset(2);
    chk("reset_empty", 64'(bus.empty), 64'd1);
    chk("reset_full", 64'(bus.st_full), 64'd0);
    chk("reset_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("reset_overflow", 64'(bus.overflow), 64'd0);
    chk("reset_ld_hit", 64'(bus.ld_hit), 64'd0);

    // Single store, mem_ready high from the start (ignored while empty)
    cycle(1'b1, 32'h54, 32'h7, 1'b1, 1'b0);
    chk("single_mem_valid", 64'(bus.mem_valid), 64'd1);
    chk("single_mem_addr", 64'(bus.mem_addr), 64'h54);
    chk("single_mem_data", 64'(bus.mem_data), 64'h7);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("single_drained", 64'(bus.empty), 64'd1);

    // Table: fill, overflow, stall, drain
    for (int i = 0; i < 10; i++) begin
      cycle(tbl[i].sv, tbl[i].a, tbl[i].d, tbl[i].mr, 1'b0);
      chk($sformatf("tbl%0d_empty", i), 64'(bus.empty), 64'(tbl[i].e_empty));
      chk($sformatf("tbl%0d_full", i), 64'(bus.st_full), 64'(tbl[i].e_full));
      chk($sformatf("tbl%0d_mem_valid", i), 64'(bus.mem_valid), 64'(tbl[i].e_mv));
      chk($sformatf("tbl%0d_overflow", i), 64'(bus.overflow), 64'(tbl[i].e_ovf));
      if (tbl[i].e_mv) begin
        chk($sformatf("tbl%0d_mem_addr", i), 64'(bus.mem_addr), 64'(tbl[i].e_addr));
        chk($sformatf("tbl%0d_mem_data", i), 64'(bus.mem_data), 64'(tbl[i].e_data));
      end
    end

    // Simultaneous push/pop at count=DEPTH-1
    do_reset(1);
    cycle(1'b1, 32'h30, 32'h7, 1'b0, 1'b0);
    cycle(1'b1, 32'h34, 32'h8, 1'b0, 1'b0);
    cycle(1'b1, 32'h38, 32'h9, 1'b0, 1'b0);
    cycle(1'b1, 32'h40, 32'hA, 1'b1, 1'b0);
    chk("pp_not_full", 64'(bus.st_full), 64'd0);
    chk("pp_head_data", 64'(bus.mem_data), 64'h8);
    cycle(1'b1, 32'h44, 32'hB, 1'b0, 1'b0);
    chk("pp_full_after_one", 64'(bus.st_full), 64'd1);
    chk("pp_no_overflow", 64'(bus.overflow), 64'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("pp_drain%0d", i), 64'(bus.mem_data), 64'(32'h8 + i));
      cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    end
    chk("pp_drained", 64'(bus.empty), 64'd1);

    // Reset mid-operation with a stalled head
    cycle(1'b1, 32'h60, 32'h1, 1'b0, 1'b0);
    cycle(1'b1, 32'h64, 32'h2, 1'b0, 1'b0);
    cycle(1'b1, 32'h68, 32'h3, 1'b0, 1'b0);
    do_reset(1);
    chk("rst_mid_empty", 64'(bus.empty), 64'd1);
    chk("rst_mid_mem_valid", 64'(bus.mem_valid), 64'd0);
    chk("rst_mid_full", 64'(bus.st_full), 64'd0);
    cycle(1'b1, 32'h70, 32'h55, 1'b0, 1'b0);
    chk("rst_mid_addr", 64'(bus.mem_addr), 64'h70);
    chk("rst_mid_data", 64'(bus.mem_data), 64'h55);
    cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    chk("rst_mid_sole", 64'(bus.empty), 64'd1);

`ifdef STORE_FWD_EN
    // Forwarding: youngest match wins, word-granular compare
    do_reset(1);
    cycle(1'b1, 32'h50, 32'h11, 1'b0, 1'b0);
    cycle(1'b1, 32'h50, 32'h22, 1'b0, 1'b0);
    bus.st_valid = 1'b0;
    bus.ld_addr  = 32'h50;
    #1;
    chk("fwd_hit", 64'(bus.ld_hit), 64'd1);
    chk("fwd_data", 64'(bus.ld_data), 64'h22);
    bus.ld_addr = 32'h53;
    #1;
    chk("fwd_word_hit", 64'(bus.ld_hit), 64'd1);
    bus.ld_addr = 32'h60;
    #1;
    chk("fwd_miss", 64'(bus.ld_hit), 64'd0);
    @(posedge clk);
    #1;
`else
    bus.ld_addr = 32'h70;
    #1;
    chk("nofwd_hit", 64'(bus.ld_hit), 64'd0);
`endif

    // Randomized traffic against the queue model
    do_reset(1);
    for (int i = 0; i < 400; i++) begin
      logic          sv, mr;
      logic [AW-1:0] a;
      bus.ld_addr = AW'($urandom_range(0, 63));
      sv = ($urandom_range(0, 9) < 6);
      a  = AW'($urandom_range(0, 15)) << 2;
      if (i < 200) mr = ($urandom_range(0, 3) == 0);
      else         mr = ($urandom_range(0, 3) != 0);
      cycle(sv, a, DW'($urandom), mr, 1'b1);
      check_model($sformatf("rand%0d", i));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
